// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - iterative unsigned MUL/MULHU/DIVU/REMU sequencer driving an external ALU
module mdu_seq #(
   parameter int         W          = 32,
   parameter int         CW         = $clog2(W) + 1,
   parameter logic [3:0] ALU_OP_ADD = 4'd0,
   parameter logic [3:0] ALU_OP_SUB = 4'd1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [1:0]   req_op,
   input  logic [W-1:0] req_a,
   input  logic [W-1:0] req_b,
   output logic         resp_valid,
   input  logic         resp_ready,
   output logic [W-1:0] resp_data,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   output logic [3:0]   alu_op,
   input  logic [W-1:0] alu_y
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    op_q, op_d;
   // acc holds hi (multiply) or rem (divide); lo holds lo or quo; opb holds mc or dv
   logic [W-1:0]  acc_q, acc_d;
   logic [W-1:0]  lo_q, lo_d;
   logic [W-1:0]  opb_q, opb_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  res_q, res_d;

   logic          is_div;
   logic [W-1:0]  div_t;
   logic          div_ge;
   logic          mul_carry;
   logic          last_iter;

   assign is_div    = op_q[1];
   // Restoring divide: shift the next dividend bit into the partial remainder.
   // A set rem msb means the shifted value exceeds W bits and is always >= dv.
   assign div_t     = {acc_q[W-2:0], lo_q[W-1]};
   assign div_ge    = acc_q[W-1] || (div_t >= opb_q);
   // Unsigned add overflowed iff the sum wrapped below one operand.
   assign mul_carry = (alu_y < acc_q);
   assign last_iter = (cnt_q == CW'(W - 1));

   assign req_ready  = (state_q == S_IDLE);
   assign resp_valid = (state_q == S_DONE);
   assign resp_data  = res_q;

   // Next-state, datapath update and ALU drive.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      acc_d   = acc_q;
      lo_d    = lo_q;
      opb_d   = opb_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      alu_a   = '0;
      alu_b   = '0;
      alu_op  = ALU_OP_ADD;

      if (flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  op_d  = req_op;
                  acc_d = '0;
                  lo_d  = req_a;
                  opb_d = req_b;
                  cnt_d = '0;
                  if (req_op[1] && (req_b == '0)) begin
                     // RISC-V divide-by-zero: quotient all ones, remainder = dividend
                     res_d   = req_op[0] ? req_a : '1;
                     state_d = S_DONE;
                  end else begin
                     state_d = S_CALC;
                  end
               end
            end
            S_CALC: begin
               if (!is_div) begin
                  if (lo_q[0]) begin
                     alu_op        = ALU_OP_ADD;
                     alu_a         = acc_q;
                     alu_b         = opb_q;
                     {acc_d, lo_d} = {mul_carry, alu_y, lo_q[W-1:1]};
                  end else begin
                     {acc_d, lo_d} = {1'b0, acc_q, lo_q[W-1:1]};
                  end
               end else begin
                  alu_op = ALU_OP_SUB;
                  alu_a  = div_t;
                  alu_b  = opb_q;
                  acc_d  = div_ge ? alu_y : div_t;
                  lo_d   = {lo_q[W-2:0], div_ge};
               end
               cnt_d = cnt_q + CW'(1);
               if (last_iter) begin
                  // MUL/DIVU take the low/quotient half, MULHU/REMU the high/remainder half
                  res_d   = op_q[0] ? acc_d : lo_d;
                  cnt_d   = '0;
                  state_d = S_DONE;
               end
            end
            S_DONE: begin
               if (resp_ready) begin
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         acc_q   <= '0;
         lo_q    <= '0;
         opb_q   <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         lo_q    <= lo_d;
         opb_q   <= opb_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
      end
   end

endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - self-checking bench for mdu_seq with a behavioural ALU and result model
module tb_mdu_seq;

   localparam int         W      = 32;
   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [1:0]    req_op = 2'd0;
   logic [W-1:0]  req_a = '0;
   logic [W-1:0]  req_b = '0;
   logic          resp_valid;
   logic          resp_ready = 1'b0;
   logic [W-1:0]  resp_data;
   logic [W-1:0]  alu_a;
   logic [W-1:0]  alu_b;
   logic [3:0]    alu_op;
   logic [W-1:0]  alu_y;

   int n_pass  = 0;
   int n_total = 0;

   mdu_seq #(.W(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_y      (alu_y)
   );

   always #5 clk = ~clk;

   assign alu_y = (alu_op == OP_SUB) ? (alu_a - alu_b) : (alu_a + alu_b);

   function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      p = {32'd0, a} * {32'd0, b};
      case (op)
         2'd0:    return p[31:0];
         2'd1:    return p[63:32];
         2'd2:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         default: return (b == 32'd0) ? a : a % b;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   // Issue one request, measure latency, optionally back-pressure, then take the response.
   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int hold);
      int   lat;
      int   wait_n;
      int   exp_lat;
      logic [31:0] held;
      logic stable;
      wait_n = 0;
      while (!req_ready && wait_n < 100) begin
         @(negedge clk);
         wait_n++;
      end
      check({tag, " req_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      @(negedge clk);
      req_valid = 1'b0;
      req_op    = 2'($urandom);
      req_a     = $urandom;
      req_b     = $urandom;
      lat = 1;
      while (!resp_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      exp_lat = (op[1] && b == 32'd0) ? 1 : W + 1;
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " result"}, resp_data, ref_result(op, a, b));
      held   = resp_data;
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (resp_data !== held || resp_valid !== 1'b1 || req_ready !== 1'b0) stable = 1'b0;
      end
      if (hold > 0) check({tag, " backpressure hold"}, 32'(stable), 32'd1);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      check({tag, " release"}, {30'd0, resp_valid, req_ready}, 32'd1);
   endtask

   initial begin
      logic seen;
      logic [1:0]  r_op;
      logic [31:0] r_a;
      logic [31:0] r_b;

      // Reset state
      repeat (2) @(negedge clk);
      check("reset req_ready", 32'(req_ready), 32'd1);
      check("reset resp_valid", 32'(resp_valid), 32'd0);
      check("reset resp_data", resp_data, 32'd0);
      check("reset alu drive", {alu_a ^ alu_b, 28'd0, alu_op}, {32'd0, 28'd0, OP_ADD} >> 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed operations
      run_op("mul 7x6",     2'd0, 32'd7, 32'd6, 0);
      run_op("mulhu 7x6",   2'd1, 32'd7, 32'd6, 0);
      run_op("mulhu max",   2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op("mul max",     2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op("divu 100/7",  2'd2, 32'd100, 32'd7, 0);
      run_op("remu 100/7",  2'd3, 32'd100, 32'd7, 0);
      run_op("divu msb/1",  2'd2, 32'h8000_0000, 32'd1, 0);
      run_op("remu 5/max",  2'd3, 32'd5, 32'hFFFF_FFFF, 0);
      run_op("divu by 0",   2'd2, 32'd123, 32'd0, 0);
      run_op("remu by 0",   2'd3, 32'd123, 32'd0, 0);
      check("idle alu_op", 32'(alu_op), 32'(OP_ADD));
      check("idle alu_a", alu_a, 32'd0);

      // Back-pressure followed by a back-to-back request
      run_op("bp mul",      2'd0, 32'h1234, 32'h5678, 10);
      run_op("b2b mul 3x5", 2'd0, 32'd3, 32'd5, 0);

      // Flush in CALC cycle 10
      req_valid = 1'b1; req_op = 2'd0; req_a = $urandom; req_b = $urandom;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush to idle", {30'd0, resp_valid, req_ready}, 32'd1);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (resp_valid) seen = 1'b1;
      end
      check("flush no response", 32'(seen), 32'd0);
      run_op("divu 9/2", 2'd2, 32'd9, 32'd2, 0);

      // Flush overrides a request handshake, including the divide-by-zero shortcut
      req_valid = 1'b1; req_op = 2'd2; req_a = 32'd1; req_b = 32'd0; flush = 1'b1;
      @(negedge clk);
      req_valid = 1'b0; flush = 1'b0;
      check("flush drops req", {30'd0, resp_valid, req_ready}, 32'd1);

      // Asynchronous reset in CALC
      req_valid = 1'b1; req_op = 2'd1; req_a = 32'hDEAD_BEEF; req_b = 32'hCAFE_F00D;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async reset state", {30'd0, resp_valid, req_ready}, 32'd1);
      check("async reset data", resp_data, 32'd0);
      check("async reset alu", {alu_a | alu_b, 28'd0, alu_op}, {32'd0, 28'd0, OP_ADD});
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_op("after reset mul", 2'd0, 32'd1000, 32'd999, 0);

      // Randomized operations against the reference model
      for (int i = 0; i < 24; i++) begin
         r_op = 2'($urandom);
         r_a  = $urandom;
         case ($urandom_range(0, 3))
            0:       r_b = 32'd0;
            1:       r_b = 32'($urandom_range(1, 255));
            default: r_b = $urandom;
         endcase
         run_op($sformatf("rand%0d", i), r_op, r_a, r_b, int'($urandom_range(0, 3)));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Iterative unsigned multiply/divide sequencer for the RV32 core.
- Computes MUL, MULHU, DIVU and REMU by driving a dedicated ALU instance (riscv_pkg ALU_OP_ADD / ALU_OP_SUB) for one add or subtract per cycle.
- Sits beside the execute stage and talks to it over a valid/ready request/response pair.
- Only the carry/compare and shift logic are local to this block; all add/subtract arithmetic goes through the ALU.

Parameters:
- W, 32, datapath width; must match the ALU's W.
- CW, $clog2(W)+1, iteration counter width.

Ports:
- clk  input  1  clock; rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort of any in-flight operation.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_op  input  2  operation: 00 MUL, 01 MULHU, 10 DIVU, 11 REMU.
- req_a  input  W  multiplicand or dividend.
- req_b  input  W  multiplier or divisor.
- resp_valid  output  1  result present.
- resp_ready  input  1  consumer accepts the result.
- resp_data  output  W  result.
- alu_a  output  W  ALU operand a.
- alu_b  output  W  ALU operand b.
- alu_op  output  4  ALU opcode.
- alu_y  input  W  ALU result; combinational, same cycle.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_data=0, counter=0, all internal registers 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch op, a, b.
  - If op is DIVU/REMU and b==0, go to DONE with the RISC-V result: DIVU gives all ones, REMU gives a.
  - Otherwise go to CALC with counter=0.
- CALC:
  - req_ready=0.
  - One iteration per cycle for exactly W cycles, then go to DONE.
- Multiply (shift-add), registers hi=0, lo=a, mc=b. Each cycle:
  - If lo[0]: alu_op=ADD, alu_a=hi, alu_b=mc, carry=(alu_y<hi), {hi,lo}<={carry,alu_y,lo[W-1:1]}.
  - Else: {hi,lo}<={1'b0,hi,lo[W-1:1]}.
  - Final result: MUL=lo, MULHU=hi.
- Divide (restoring), registers rem=0, quo=a, dv=b. Each cycle:
  - t={rem[W-2:0],quo[W-1]}, msb=rem[W-1].
  - alu_op=SUB, alu_a=t, alu_b=dv.
  - If msb||(t>=dv): rem<=alu_y, quo<={quo[W-2:0],1}.
  - Else: rem<=t, quo<={quo[W-2:0],0}.
  - Final result: DIVU=quo, REMU=rem.
- ALU drive outside a real iteration: alu_a=alu_b=0, alu_op=ALU_OP_ADD.
- DONE:
  - resp_valid=1; resp_data is stable until the response is taken.
  - On resp_ready, go to IDLE.
  - req_ready=0 in DONE, so a new request cannot be accepted in the same cycle the response is taken.
- Latency, with the request handshake in cycle c:
  - Normal operation: first resp_valid cycle is c+W+1.
  - Divide by zero: first resp_valid cycle is c+1.
- Back-pressure: resp_valid holds indefinitely while resp_ready=0; resp_data does not change.
- flush:
  - Any state goes to IDLE on the next edge; no response is produced and resp_valid drops.
  - flush overrides a request handshake in the same cycle: the request is dropped.
  - flush also overrides a response handshake in the same cycle.
- rst_n low at any point (including during CALC) immediately forces the reset values; the operation is lost.
- req_a and req_b are sampled only at the handshake; later changes have no effect.
- resp_valid and req_ready are registered-state decodes; there is no combinational path from req_valid to any output.

Test Plan:
- MUL 7×6 → resp_data=42, resp_valid first seen exactly 33 cycles after the handshake cycle. MULHU 7×6 → 0.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MUL of the same operands → 0x00000001.
- DIVU 100/7 → 14; REMU 100/7 → 2; DIVU 0x80000000/1 → 0x80000000; REMU 5/0xFFFFFFFF → 5.
- DIVU 123/0 → 0xFFFFFFFF and REMU 123/0 → 123, each with resp_valid one cycle after the handshake.
- Hold resp_ready=0 for 10 cycles in DONE:
  - resp_data stays stable and req_ready stays 0.
  - After resp_ready=1, req_ready=1 on the next cycle and a back-to-back MUL 3×5 returns 15.
- Assert flush in CALC cycle 10 → IDLE next cycle with no resp_valid; a following DIVU 9/2 returns 4.
- Drop rst_n asynchronously in CALC → outputs take reset values at once; the next operation returns the correct result.
